// File: rtl/regbank_sb.sv
// ---------------------------------------------------------------------------
// regbank_sb -- register bank with a per-register busy scoreboard.
//
// A register is marked busy when an instruction that will write it is issued.
// The mark is cleared when that register is written back. A read port reports
// an operand as ready only when its register has no write pending.
//
// Optional feature (macro REGBANK_SB_BYPASS_EN):
//   defined   : a read that hits the register being written back in the same
//               cycle returns i_wr_data, with rdy=1.
//   undefined : such a read returns the old stored value, with rdy=~busy.
//
// Parameters:
//   DW  data width of each register
//   AW  address width; the bank holds 2**AW registers
//   NRD number of independent read ports
//
// Ports:
//   i_clk      clock; all state updates on its rising edge
//   i_rst      synchronous active-high reset
//   i_rd_addr  NRD packed read addresses, port k at [k*AW +: AW]
//   o_rd_data  NRD packed read data, port k at [k*DW +: DW] (combinational)
//   o_rd_rdy   per-port operand-ready flag (combinational)
//   i_iss_en   issue strobe; marks i_iss_addr as pending a write
//   i_iss_addr destination register being issued
//   i_wr_en    writeback strobe
//   i_wr_addr  writeback register address
//   i_wr_data  writeback data
//   o_busy     registered scoreboard, bit n=1 means register n is pending
//   o_wb_err   registered one-cycle pulse: a writeback hit a non-busy register
//
// There is no valid/ready handshake here. i_iss_en and i_wr_en are
// single-cycle strobes. Each one is acted on at the rising edge where it is
// high, and it is never back-pressured.
// ---------------------------------------------------------------------------
module regbank_sb #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NRD*AW-1:0]     i_rd_addr,
    output logic [NRD*DW-1:0]     o_rd_data,
    output logic [NRD-1:0]        o_rd_rdy,
    input  logic                  i_iss_en,
    input  logic [AW-1:0]         i_iss_addr,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DW-1:0]         i_wr_data,
    output logic [(1<<AW)-1:0]    o_busy,
    output logic                  o_wb_err
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0]   mem_q [NREG];
    logic [DW-1:0]   mem_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wb_err_q;
    logic            wb_err_d;

    // Next-state logic for the register file and the scoreboard.
    always_comb begin
        mem_d    = mem_q;
        busy_d   = busy_q;
        wb_err_d = 1'b0;

        if (i_wr_en && (i_wr_addr != '0)) begin
            mem_d[i_wr_addr] = i_wr_data;
        end

        // The writeback clears first and the issue sets after it, so when
        // both hit the same register, the newer producer keeps the bit set.
        if (i_wr_en) begin
            busy_d[i_wr_addr] = 1'b0;
        end
        if (i_iss_en) begin
            busy_d[i_iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // A writeback counts as an error only when nothing is pending on the
        // target, and no issue to the same target arrives in the same cycle.
        // An issue and a writeback to the same register in one cycle are
        // legal back-to-back producers.
        if (i_wr_en && (i_wr_addr != '0) && !busy_q[i_wr_addr] &&
            !(i_iss_en && (i_iss_addr == i_wr_addr))) begin
            wb_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < NREG; n++) begin
                mem_q[n] <= '0;
            end
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            for (int n = 0; n < NREG; n++) begin
                mem_q[n] <= mem_d[n];
            end
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_wb_err = wb_err_q;

    // Read ports.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] rd_a;
        logic          byp;
        logic [DW-1:0] rd_data;
        logic          rd_rdy;

        assign rd_a = i_rd_addr[k*AW +: AW];

`ifdef REGBANK_SB_BYPASS_EN
        // Do not forward during reset, because that writeback is discarded.
        assign byp = i_wr_en && !i_rst && (i_wr_addr == rd_a);
`else
        assign byp = 1'b0;
`endif

        always_comb begin
            rd_data = '0;
            rd_rdy  = 1'b1;
            if (rd_a == '0) begin
                rd_data = '0;
                rd_rdy  = 1'b1;
            end else if (byp) begin
                rd_data = i_wr_data;
                rd_rdy  = 1'b1;
            end else begin
                rd_data = mem_q[rd_a];
                rd_rdy  = ~busy_q[rd_a];
            end
        end

        assign o_rd_data[k*DW +: DW] = rd_data;
        assign o_rd_rdy[k]           = rd_rdy;
    end

endmodule

// File: tb/tb_regbank_sb.sv
// ---------------------------------------------------------------------------
// tb_regbank_sb -- self-checking bench for regbank_sb (DW=32, AW=5, NRD=2).
// Directed scenarios, then randomized traffic, all compared against a
// behavioural model of the register bank held in plain arrays.
// ---------------------------------------------------------------------------
module tb_regbank_sb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NREG = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DW-1:0]     rd_data;
    logic [NRD-1:0]        rd_rdy;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;
    logic [NREG-1:0]       busy;
    logic                  wb_err;

    regbank_sb #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_rdy   (rd_rdy),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_busy     (busy),
        .o_wb_err   (wb_err)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [NREG];
    bit            m_busy [NREG];
    bit            m_err;

    int total = 0;
    int bad   = 0;

    function automatic logic [NREG-1:0] m_busy_vec();
        logic [NREG-1:0] v;
        for (int n = 0; n < NREG; n++) v[n] = m_busy[n];
        return v;
    endfunction

    // Expected read result for one port, taken from the current inputs.
    task automatic m_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic r);
        if (a == 0) begin
            d = '0; r = 1'b1;
        end else begin
`ifdef REGBANK_SB_BYPASS_EN
            if (wr_en && !rst && wr_addr == a) begin
                d = wr_data; r = 1'b1;
            end else begin
                d = m_mem[a]; r = !m_busy[a];
            end
`else
            d = m_mem[a]; r = !m_busy[a];
`endif
        end
    endtask

    // Apply one rising edge to the model.
    task automatic m_edge();
        if (rst) begin
            for (int n = 0; n < NREG; n++) begin
                m_mem[n] = '0; m_busy[n] = 0;
            end
            m_err = 0;
        end else begin
            m_err = wr_en && wr_addr != 0 && !m_busy[wr_addr] &&
                    !(iss_en && iss_addr == wr_addr);
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
            if (wr_en) m_busy[wr_addr] = 0;
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
        end
    endtask

    // ---------------- checkers ----------------
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reads(input string tag);
        logic [DW-1:0] ed;
        logic          er;
        for (int k = 0; k < NRD; k++) begin
            m_read(rd_addr[k*AW +: AW], ed, er);
            chk32($sformatf("%s rd_data%0d", tag, k), rd_data[k*DW +: DW], ed);
            chk32($sformatf("%s rd_rdy%0d", tag, k), {31'd0, rd_rdy[k]}, {31'd0, er});
        end
    endtask

    task automatic chk_regs(input string tag);
        chk32({tag, " busy"}, busy, m_busy_vec());
        chk32({tag, " wb_err"}, {31'd0, wb_err}, {31'd0, m_err});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic ie, input logic [AW-1:0] ia,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        rst = r; iss_en = ie; iss_addr = ia;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr = {ra1, ra0};
    endtask

    // One cycle: the inputs are already driven after a negedge. Check the
    // combinational reads, clock the DUT and the model, then check the
    // registered outputs, and return at the next negedge.
    task automatic cycle(input string tag, input bit check_rd);
        #1;
        if (check_rd) chk_reads(tag);
        @(posedge clk);
        m_edge();
        #1;
        chk_regs(tag);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < NREG; n++) begin
            m_mem[n] = '0; m_busy[n] = 0;
        end
        m_err = 0;
        @(negedge clk);
        // The first reset edge: the DUT state is still unknown before it.
        cycle("reset0", 1'b0);
        // A reset with an issue and a writeback pending: the reset wins.
        drive(1'b1, 1, 5'd4, 1, 5'd4, 32'h1111_2222, 5'd0, 5'd5);
        cycle("reset1", 1'b0);

        // Read r0 and r5 on both ports after reset.
        drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd5);
        #1;
        chk32("post_reset r0", rd_data[31:0], 32'h0);
        chk32("post_reset r5", rd_data[63:32], 32'h0);
        chk32("post_reset rdy", {30'd0, rd_rdy}, 32'd3);
        chk32("post_reset busy", busy, 32'h0);
        cycle("idle_r0_r5", 1'b1);

        // Issue r5, then check that r5 is not ready.
        drive(0, 1, 5'd5, 0, 0, 0, 5'd5, 5'd5);
        cycle("iss_r5", 1'b1);
        drive(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        #1;
`ifndef REGBANK_SB_BYPASS_EN
        chk32("r5 pending rdy", {30'd0, rd_rdy}, 32'd0);
`endif
        cycle("wb_r5", 1'b1);
        drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        #1;
        chk32("r5 data", rd_data[31:0], 32'hDEAD_BEEF);
        chk32("r5 rdy", {31'd0, rd_rdy[0]}, 32'd1);
        chk32("r5 busy", {31'd0, busy[5]}, 32'd0);
        cycle("rd_r5", 1'b1);

        // Issue r7 and write r7 in the same cycle: the set wins, and no error.
        drive(0, 1, 5'd7, 1, 5'd7, 32'h1234, 5'd7, 5'd7);
        cycle("iss_wb_r7", 1'b1);
        chk32("r7 busy", {31'd0, busy[7]}, 32'd1);
        chk32("r7 wb_err", {31'd0, wb_err}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
        #1;
        chk32("r7 data", rd_data[31:0], 32'h1234);
        cycle("rd_r7", 1'b1);

        // A writeback to the non-busy r9 pulses wb_err for one cycle.
        drive(0, 0, 0, 1, 5'd9, 32'h55, 5'd9, 5'd0);
        cycle("wb_r9", 1'b1);
        chk32("r9 wb_err pulse", {31'd0, wb_err}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
        #1;
        chk32("r9 data", rd_data[63:32], 32'h55);
        cycle("rd_r9", 1'b1);
        chk32("r9 wb_err drop", {31'd0, wb_err}, 32'd0);

        // Busy r3, then read r3 on both ports while r3 is written back.
        drive(0, 1, 5'd3, 0, 0, 0, 5'd3, 5'd3);
        cycle("iss_r3", 1'b1);
        drive(0, 0, 0, 1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3);
        #1;
`ifdef REGBANK_SB_BYPASS_EN
        chk32("r3 bypass data", rd_data[63:32], 32'hA5A5_A5A5);
        chk32("r3 bypass rdy", {30'd0, rd_rdy}, 32'd3);
`else
        chk32("r3 old data", rd_data[63:32], 32'h0);
        chk32("r3 old rdy", {30'd0, rd_rdy}, 32'd0);
`endif
        cycle("wb_r3", 1'b1);

        // Issue r4 while in reset, after r4 has been written first.
        drive(0, 0, 0, 1, 5'd4, 32'hCAFE, 5'd4, 5'd4);
        cycle("wb_r4", 1'b1);
        drive(1, 1, 5'd4, 0, 0, 0, 5'd4, 5'd4);
        cycle("rst_iss_r4", 1'b1);
        drive(0, 0, 0, 0, 0, 0, 5'd4, 5'd4);
        #1;
        chk32("r4 after reset busy", {31'd0, busy[4]}, 32'd0);
        chk32("r4 after reset data", rd_data[31:0], 32'h0);
        chk32("r4 after reset wb_err", {31'd0, wb_err}, 32'd0);
        cycle("rd_r4", 1'b1);

        // Randomized traffic. Small addresses are favoured to force collisions.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] ia, wa, r0, r1;
            ia = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            r0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 2) == 0) ? ia : AW'($urandom_range(0, 31));
            drive(($urandom_range(0, 60) == 0), $urandom_range(0, 1), ia,
                  $urandom_range(0, 1), wa, $urandom(), r0, r1);
            cycle("rand", 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
